// File: rtl/rf_sample_capture_writer_if.sv
// Sample stream and buffer write port bundle for rf_sample_capture_writer.
// SAMPLE_PACK_EN narrows s_data to half a buffer word.
interface rf_sample_capture_writer_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
`ifdef SAMPLE_PACK_EN
  localparam int unsigned SW = DATA_WIDTH / 2;
`else
  localparam int unsigned SW = DATA_WIDTH;
`endif

  logic                  s_valid;
  logic [SW-1:0]         s_data;
  logic                  s_ready;
  logic                  buf_write;
  logic [ADDR_WIDTH-1:0] buf_addr;
  logic [DATA_WIDTH-1:0] buf_data;

  // master: the capture writer (owns the buffer write port, consumes the stream)
  modport master (
    input  s_valid, s_data,
    output s_ready, buf_write, buf_addr, buf_data
  );

  // slave: the sample source and buffer
  modport slave (
    output s_valid, s_data,
    input  s_ready, buf_write, buf_addr, buf_data
  );
endinterface

// File: rtl/rf_sample_capture_writer.sv
// Captures a frame of RF samples into consecutive (wrapping) buffer words.
// SAMPLE_PACK_EN: two half-width beats form one buffer word (low half first).
module rf_sample_capture_writer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   frame_len,
  rf_sample_capture_writer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   words_written
);
  localparam int unsigned CW = ADDR_WIDTH + 1;
`ifdef SAMPLE_PACK_EN
  localparam int unsigned SW = DATA_WIDTH / 2;
`else
  localparam int unsigned SW = DATA_WIDTH;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_CAPTURE, ST_DONE} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] ptr, ptr_nxt;
  logic [CW-1:0]         remaining, remaining_nxt;
  logic [CW-1:0]         words_written_nxt;
  logic                  done_nxt;
  logic                  buf_write_nxt;
  logic [ADDR_WIDTH-1:0] buf_addr_nxt;
  logic [DATA_WIDTH-1:0] buf_data_nxt;
  logic                  s_ready_c;
  logic                  accept;
  logic                  word_done;
  logic [SW-1:0]         beat;
  logic [DATA_WIDTH-1:0] word;
`ifdef SAMPLE_PACK_EN
  logic                  half_pending, half_pending_nxt;
  logic [SW-1:0]         half_lo, half_lo_nxt;
`endif

  assign busy        = (state != ST_IDLE);
  assign bus.s_ready = s_ready_c;

  // Next-state, datapath and write-strobe decode
  always_comb begin
    state_nxt         = state;
    ptr_nxt           = ptr;
    remaining_nxt     = remaining;
    words_written_nxt = words_written;
    done_nxt          = 1'b0;
    buf_write_nxt     = 1'b0;
    buf_addr_nxt      = bus.buf_addr;
    buf_data_nxt      = bus.buf_data;
    s_ready_c         = 1'b0;
    accept            = 1'b0;
    word_done         = 1'b0;
    beat              = bus.s_data;
    word              = '0;
`ifdef SAMPLE_PACK_EN
    half_pending_nxt  = half_pending;
    half_lo_nxt       = half_lo;
`endif

    case (state)
      ST_IDLE: begin
        if (start) begin
          ptr_nxt           = base_addr;
          remaining_nxt     = frame_len;
          words_written_nxt = '0;
`ifdef SAMPLE_PACK_EN
          half_pending_nxt  = 1'b0;
`endif
          if (frame_len == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        s_ready_c = !abort;
        accept    = bus.s_valid && !abort;
        if (abort) begin
          state_nxt = ST_IDLE;
`ifdef SAMPLE_PACK_EN
          half_pending_nxt = 1'b0;
`endif
        end else if (accept) begin
`ifdef SAMPLE_PACK_EN
          if (half_pending) begin
            word_done        = 1'b1;
            word             = {beat, half_lo};
            half_pending_nxt = 1'b0;
          end else begin
            half_lo_nxt      = beat;
            half_pending_nxt = 1'b1;
          end
`else
          word_done = 1'b1;
          word      = beat;
`endif
        end

        if (word_done) begin
          buf_write_nxt     = 1'b1;
          buf_addr_nxt      = ptr;
          buf_data_nxt      = word;
          ptr_nxt           = ptr + ADDR_WIDTH'(1);
          remaining_nxt     = remaining - CW'(1);
          words_written_nxt = words_written + CW'(1);
          if (remaining == CW'(1)) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end
        end
      end

      ST_DONE: state_nxt = ST_IDLE;

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      ptr           <= '0;
      remaining     <= '0;
      words_written <= '0;
      done          <= 1'b0;
      bus.buf_write <= 1'b0;
      bus.buf_addr  <= '0;
      bus.buf_data  <= '0;
`ifdef SAMPLE_PACK_EN
      half_pending  <= 1'b0;
      half_lo       <= '0;
`endif
    end else begin
      state         <= state_nxt;
      ptr           <= ptr_nxt;
      remaining     <= remaining_nxt;
      words_written <= words_written_nxt;
      done          <= done_nxt;
      bus.buf_write <= buf_write_nxt;
      bus.buf_addr  <= buf_addr_nxt;
      bus.buf_data  <= buf_data_nxt;
`ifdef SAMPLE_PACK_EN
      half_pending  <= half_pending_nxt;
      half_lo       <= half_lo_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_rf_sample_capture_writer.sv
// Scoreboard bench for rf_sample_capture_writer: expected writes are queued on accept
// and compared (address, data, one-cycle latency) when the write strobe appears.
module tb_rf_sample_capture_writer;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = AW + 1;
`ifdef SAMPLE_PACK_EN
  localparam int unsigned SW = DW / 2;
`else
  localparam int unsigned SW = DW;
`endif
  localparam time HALF = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] frame_len = '0;
  logic          busy;
  logic          done;
  logic [CW-1:0] words_written;

  rf_sample_capture_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rf_sample_capture_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .base_addr     (base_addr),
    .frame_len     (frame_len),
    .bus           (bus),
    .busy          (busy),
    .done          (done),
    .words_written (words_written)
  );

  always #HALF clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    time           t;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_writes = 0;
  int            n_done = 0;
  logic [AW-1:0] m_ptr = '0;
  logic [SW-1:0] m_lo = '0;
  bit            m_half = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model: called at the clock edge on which a beat is accepted
  task automatic model_accept(input logic [SW-1:0] d);
`ifdef SAMPLE_PACK_EN
    if (!m_half) begin
      m_lo   = d;
      m_half = 1'b1;
    end else begin
      sb.push_back('{m_ptr, {d, m_lo}, $time});
      m_ptr  = m_ptr + AW'(1);
      m_half = 1'b0;
    end
`else
    sb.push_back('{m_ptr, d, $time});
    m_ptr = m_ptr + AW'(1);
`endif
  endtask

  // Write monitor, sampling half a cycle after the active edge
  always @(negedge clk) begin
    if (!reset) begin
      if (done) n_done++;
      if (bus.buf_write) begin
        n_writes++;
        if (sb.size() == 0) begin
          check("spurious_write", 64'(bus.buf_write), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          check("write_addr", 64'(bus.buf_addr), 64'(mon_e.addr));
          check("write_data", 64'(bus.buf_data), 64'(mon_e.data));
          check("write_latency", 64'($time - mon_e.t), 64'(HALF));
        end
      end
    end
  end

  // Offer one beat starting just after a negedge; returns at the negedge after acceptance
  task automatic send_beat(input logic [SW-1:0] d);
    bit ok;
    ok = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (bus.s_ready) begin
        @(posedge clk);
        model_accept(d);
        ok = 1'b1;
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    check("beat_accept", 64'(ok), 64'd1);
  endtask

  task automatic gap_cycle();
    bus.s_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w, input bit gap);
`ifdef SAMPLE_PACK_EN
    send_beat(w[SW-1:0]);
    if (gap) gap_cycle();
    send_beat(w[DW-1:SW]);
`else
    send_beat(w);
`endif
    if (gap) gap_cycle();
  endtask

  task automatic arm(input logic [AW-1:0] base, input logic [CW-1:0] len);
    base_addr = base;
    frame_len = len;
    start     = 1'b1;
    m_ptr     = base;
    m_half    = 1'b0;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0;
    int w0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;

    #1;
    check("rst_buf_write", 64'(bus.buf_write), 64'd0);
    check("rst_buf_addr", 64'(bus.buf_addr), 64'd0);
    check("rst_buf_data", 64'(bus.buf_data), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_words_written", 64'(words_written), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame, valid held high
    d0 = n_done; w0 = n_writes;
    arm(10'h010, 11'd4);
    check("t1_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 4; i++) send_word(DW'(32'hA0 + i), 1'b0);
    bus.s_valid = 1'b0;
    check("t1_done_pulse", 64'(done), 64'd1);
    check("t1_last_addr", 64'(bus.buf_addr), 64'h013);
    check("t1_last_data", 64'(bus.buf_data), 64'hA3);
    @(negedge clk);
    check("t1_done_low", 64'(done), 64'd0);
    check("t1_idle", 64'(busy), 64'd0);
    check("t1_words_written", 64'(words_written), 64'd4);

    // Back-to-back start in the IDLE cycle after DONE, with address wrap
    arm(10'h3FE, 11'd4);
    check("t1_writes", 64'(n_writes - w0), 64'd4);
    check("t1_done_count", 64'(n_done - d0), 64'd1);
    check("t2_busy", 64'(busy), 64'd1);
    check("t2_ww_cleared", 64'(words_written), 64'd0);
    d0 = n_done; w0 = n_writes;
    for (int i = 0; i < 4; i++) send_word(DW'(32'hB0 + i), 1'b0);
    bus.s_valid = 1'b0;
    check("t2_wrap_addr", 64'(bus.buf_addr), 64'h001);
    idle(3);
    check("t2_writes", 64'(n_writes - w0), 64'd4);
    check("t2_done_count", 64'(n_done - d0), 64'd1);
    check("t2_words_written", 64'(words_written), 64'd4);

    // Zero-length frame
    d0 = n_done; w0 = n_writes;
    arm(10'h123, 11'd0);
    check("t3_busy", 64'(busy), 64'd1);
    check("t3_done", 64'(done), 64'd1);
    @(negedge clk);
    check("t3_busy_low", 64'(busy), 64'd0);
    check("t3_done_low", 64'(done), 64'd0);
    idle(2);
    check("t3_writes", 64'(n_writes - w0), 64'd0);
    check("t3_done_count", 64'(n_done - d0), 64'd1);

    // Abort after three writes; start during capture is ignored
    d0 = n_done; w0 = n_writes;
    arm(10'h100, 11'd8);
    send_word(DW'(32'hD0), 1'b0);
    send_word(DW'(32'hD1), 1'b0);
    bus.s_valid = 1'b0;
    base_addr = 10'h2AA;
    frame_len = 11'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t4_busy_after_start", 64'(busy), 64'd1);
    send_word(DW'(32'hD2), 1'b0);
    bus.s_data = '1;
    abort = 1'b1;
    #1;
    check("t4_ready_in_abort", 64'(bus.s_ready), 64'd0);
    @(negedge clk);
    abort = 1'b0;
    bus.s_valid = 1'b0;
    check("t4_idle", 64'(busy), 64'd0);
    check("t4_no_done", 64'(done), 64'd0);
    idle(3);
    check("t4_words_written", 64'(words_written), 64'd3);
    check("t4_writes", 64'(n_writes - w0), 64'd3);
    check("t4_done_count", 64'(n_done - d0), 64'd0);
    check("t4_sb_empty", 64'(sb.size()), 64'd0);

    // Toggling valid
    d0 = n_done; w0 = n_writes;
    arm(10'h020, 11'd3);
    for (int i = 0; i < 3; i++) send_word(DW'(32'hC0 + i), 1'b1);
    idle(3);
    check("t5_writes", 64'(n_writes - w0), 64'd3);
    check("t5_done_count", 64'(n_done - d0), 64'd1);
    check("t5_words_written", 64'(words_written), 64'd3);
    check("t5_sb_empty", 64'(sb.size()), 64'd0);

    // Packing frame (plain words when packing is disabled)
    w0 = n_writes;
    arm(10'h050, 11'd2);
`ifdef SAMPLE_PACK_EN
    send_beat(16'h1111);
    send_beat(16'h2222);
    send_beat(16'h3333);
    send_beat(16'h4444);
`else
    send_beat(32'h2222_1111);
    send_beat(32'h4444_3333);
`endif
    bus.s_valid = 1'b0;
    check("t6_last_data", 64'(bus.buf_data), 64'h4444_3333);
    idle(3);
    check("t6_writes", 64'(n_writes - w0), 64'd2);

    // Reset mid-frame drops everything, including a pending half word
    w0 = n_writes;
    arm(10'h060, 11'd4);
`ifdef SAMPLE_PACK_EN
    send_beat(16'h5555);
`endif
    bus.s_valid = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    check("t7_buf_write", 64'(bus.buf_write), 64'd0);
    check("t7_buf_addr", 64'(bus.buf_addr), 64'd0);
    check("t7_buf_data", 64'(bus.buf_data), 64'd0);
    check("t7_done", 64'(done), 64'd0);
    check("t7_words_written", 64'(words_written), 64'd0);
    check("t7_busy", 64'(busy), 64'd0);
    m_half = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    idle(2);
    check("t7_writes", 64'(n_writes - w0), 64'd0);

    // Fresh one-word frame after reset must not reuse the dropped half
    arm(10'h070, 11'd1);
    send_word(DW'(32'h7777_6666), 1'b0);
    bus.s_valid = 1'b0;
    check("t8_data", 64'(bus.buf_data), 64'h7777_6666);
    check("t8_addr", 64'(bus.buf_addr), 64'h070);
    idle(3);
    check("t8_sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
